fetch_sequencer: RTL

- Multi-cycle fetch controller that owns the program counter and sequences instruction memory reads through a req/ready handshake.
- Holds each fetched word until the downstream decode/execute stage accepts it.
- Applies sequential (PC+4) or branch (PC+4+sext(imm16)<<2) next-PC selection, and detects a halt word.
- Sits between the instruction SRAM (or a future cache) and the decode stage, replacing free-running per-cycle PC update.

---
 rtl/fetch_sequencer_pkg.sv | 18 +
 rtl/fetch_sequencer_next_pc_calc.sv | 26 ++
 rtl/fetch_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared constants for fetch_sequencer: FSM encodings, default boot/halt values,
// and the 16-to-30-bit sign extender used for branch offsets.
package fetch_sequencer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  localparam logic [31:0] DEF_BOOT_PC   = 32'h0040_0020;
  localparam logic [31:0] DEF_HALT_WORD = 32'h0000_000C;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 16;

  function automatic logic [29:0] sext16_to_30(input logic [15:0] v);
    return {{14{v[15]}}, v};
  endfunction

endpackage

// File: rtl/fetch_sequencer_next_pc_calc.sv
// Combinational next-PC on word addresses: cur_pc + 1, plus sign-extended imm16 when
// a branch is taken. Wraps modulo 2^30 words.
module next_pc_calc
  import fetch_sequencer_pkg::*;
(
  input  logic [31:2] cur_pc,
  input  logic [15:0] imm16,
  input  logic        take_branch,
  output logic [31:2] next_pc
);

  logic [29:0] offset_s;

  // Branch offset is zero on the sequential path.
  always_comb begin
    offset_s = 30'd0;
    if (take_branch) begin
      offset_s = sext16_to_30(imm16);
    end else begin
      offset_s = 30'd0;
    end
  end

  assign next_pc = cur_pc + 30'd1 + offset_s;

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch controller: owns the PC, issues imem requests, holds each word
// until accepted, halts on HALT_WORD. Optional imem timeout under FETCH_TIMEOUT_EN.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] BOOT_PC   = DEF_BOOT_PC,
  parameter logic [31:0] HALT_WORD = DEF_HALT_WORD
`ifdef FETCH_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_accept,
  input  logic        branch_taken,
  output logic        halt,
  output logic        fetch_err
);

  logic [1:0]  state_q, state_d;
  logic [31:2] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [31:2] next_pc_s;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fetch_err_q, fetch_err_d;
`endif

  next_pc_calc u_next_pc (
    .cur_pc      (instr_pc_q[31:2]),
    .imm16       (instr_q[15:0]),
    .take_branch (branch_taken),
    .next_pc     (next_pc_s)
  );

  // FSM and datapath next-state.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d       = cnt_q;
    fetch_err_d = fetch_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_REQ;
          pc_d    = BOOT_PC[31:2];
`ifdef FETCH_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (imem_ready) begin
          instr_d    = imem_rdata;
          instr_pc_d = {pc_q, 2'b00};
          state_d    = ST_HOLD;
        end else begin
`ifdef FETCH_TIMEOUT_EN
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
            state_d     = ST_HALT;
            fetch_err_d = 1'b1;
          end else begin
            state_d = ST_REQ;
          end
`else
          state_d = ST_REQ;
`endif
        end
      end
      ST_HOLD: begin
        if (instr_accept) begin
          // A halt word wins over any branch qualification.
          if (instr_q == HALT_WORD) begin
            state_d = ST_HALT;
          end else begin
            pc_d    = next_pc_s;
            state_d = ST_REQ;
`ifdef FETCH_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= BOOT_PC[31:2];
      instr_q    <= 32'h0000_0000;
      instr_pc_q <= 32'h0000_0000;
`ifdef FETCH_TIMEOUT_EN
      cnt_q       <= '0;
      fetch_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q       <= cnt_d;
      fetch_err_q <= fetch_err_d;
`endif
    end
  end

  assign imem_req    = (state_q == ST_REQ);
  assign imem_addr   = {pc_q, 2'b00};
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = (state_q == ST_HOLD);
  assign halt        = (state_q == ST_HALT);
`ifdef FETCH_TIMEOUT_EN
  assign fetch_err   = fetch_err_q;
`else
  assign fetch_err   = 1'b0;
`endif

endmodule
